if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register, directly upstream of the control decoder.
- Holds the PC and fetches instructions over a req/ack instruction-memory handshake.
- Presents funcode/rt/specialcode fields to the decoder.
- Takes the decoder's jump/jumpReg/branch resolution back to redirect the PC. No branch delay slot: the redirect flushes the wrong-path fetch.

Parameters:
RESET_PC, 32'h0000_3000, first fetch address after reset
ADDR_W, 32, PC / address width (fixed at 32; parameter is for documentation only)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, held until accepted
imem_addr  out  32  fetch address, word aligned
imem_ack  in  1  memory accepts request; imem_rdata valid same cycle
imem_rdata  in  32  returned instruction
stall  in  1  hazard unit: hold IF/ID contents
jump  in  1  decoder: J/JAL/JR/JALR in ID
jump_reg  in  1  decoder: JR/JALR (target from register)
branch_taken  in  1  branch in ID resolved taken
jump_index  in  26  instr[25:0] of the ID instruction
branch_off  in  16  instr[15:0] of the ID instruction
reg_target  in  32  rs value for JR/JALR
id_valid  out  1  IF/ID holds a live instruction
id_instr  out  32  IF/ID instruction
id_pc  out  32  PC of id_instr
id_pc_plus4  out  32  id_pc+4 (link value)
funcode  out  6  id_instr[31:26]
rt  out  5  id_instr[20:16]
specialcode  out  6  id_instr[5:0]
misalign  out  1  one-cycle pulse: reg_target[1:0]!=0 on a taken jump_reg

Behaviour:
Reset (async, rst_n=0):
- imem_req=0, imem_addr=RESET_PC.
- id_valid=0; id_instr, id_pc, id_pc_plus4, funcode, rt, specialcode = 0; misalign=0.
- Internal fetch PC = RESET_PC; skid buffer empty; state = IDLE.

Reset mid-operation:
- Takes effect immediately: req drops the same instant.
- An ack arriving while imem_req=0 is ignored.

State machine:
- IDLE: one cycle after reset release, then REQ.
- REQ: imem_req=1, imem_addr=fetch PC.
  - On clk edge with imem_ack=1: the instruction is accepted and the fetch PC advances by 4.
  - imem_addr and req stay stable while unacked.
- DROP: a redirect occurred while a request was outstanding. Req and addr stay stable until ack, the returned data is discarded, and the state returns to REQ with the target address in the following cycle.
- FULL: an instruction was accepted while IF/ID was held by stall. It is stored in a one-entry skid buffer and imem_req=0. When stall drops, the buffer moves into IF/ID, and REQ resumes the next cycle.

Throughput and latency:
- With ack tied high, one instruction per cycle.
- id_valid first rises 2 cycles after reset release: IDLE, then REQ, accepted at the second edge.

IF/ID update (when stall=0):
- Loads the accepted (or buffered) instruction with its PC.
- Otherwise id_valid=0 (bubble).

Stall with id_valid=1:
- All id_* outputs hold.
- Redirect inputs are ignored.

Redirect:
- Evaluated only when id_valid=1 and stall=0.
- Priority: jump_reg, then jump, then branch_taken.
- Targets:
  - jump_reg: {reg_target[31:2],2'b00}; misalign pulses if reg_target[1:0]!=0.
  - jump: {id_pc_plus4[31:28], jump_index, 2'b00}.
  - branch: id_pc_plus4 + sign-extended branch_off<<2, modulo 2^32 (wrap-around permitted, no exception).
- Effects:
  - Next cycle id_valid=0 (flush).
  - The fetch PC is loaded with the target.
  - Any instruction accepted in the same cycle is discarded.
  - An unacked outstanding request sends the FSM to DROP.
- A redirect with the skid buffer full clears the buffer.

Fields: funcode/rt/specialcode are pure slices of id_instr; id_pc_plus4 = id_pc+4, wrapping at 2^32.

Never: duplicate or skip an instruction on the sequential path; change imem_addr while imem_req=1 and unacked.

Test Plan:
1. Reset release, ack=1 constant -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; id_valid=1 from cycle 2 with id_pc=0x3000, then +4 per cycle.
2. id_pc=0x3004, jump=1, jump_index=26'h0000C10 -> next imem_addr=0x00003040; following id_valid=0 for one cycle; then id_pc=0x3040.
3. id_pc=0x3008, branch_taken=1, branch_off=16'hFFFF -> target 0x3008 (pc+4-4); next id_pc=0x3008.
4. Ack latency 3 cycles, redirect to 0x3100 on the first wait cycle -> imem_addr held at the old value until ack; returned data never reaches id_instr; next request addr=0x3100.
5. Ack=1, stall high 3 cycles -> id_instr constant; exactly one instruction buffered; imem_req=0 during stall; after release, id_pc sequence continues +4 with no gap or repeat.
6. jump_reg=1, reg_target=0x00003011 -> imem_addr=0x00003010 and misalign pulse of one cycle. Separately, rst_n low during a wait -> imem_req=0 immediately; after release, fetch restarts at 0x3000.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch over a req/ack memory handshake plus the IF/ID register.
// Redirects from ID flush the wrong-path fetch; a one-entry skid buffer absorbs an accept during stall.
module if_stage #(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              jump,
    input  logic              jump_reg,
    input  logic              branch_taken,
    input  logic [25:0]       jump_index,
    input  logic [15:0]       branch_off,
    input  logic [31:0]       reg_target,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_plus4,
    output logic [5:0]        funcode,
    output logic [4:0]        rt,
    output logic [5:0]        specialcode,
    output logic              misalign
);
    typedef enum logic [1:0] {IDLE, REQ, DROP, FULL} state_t;
    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] skid_pc;
    logic [31:0]       skid_instr;
    logic              acc;
    logic              redir;
    logic              load_skid;
    logic              load_mem;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] src_pc;
    assign acc = imem_req && imem_ack;
    assign redir = id_valid && !stall && (jump_reg || jump || branch_taken);
    assign load_skid = state == FULL && !stall && !redir;
    assign load_mem = state == REQ && acc && !stall && !redir;
    assign src_pc = load_skid ? skid_pc : imem_addr;
    assign funcode = id_instr[31:26];
    assign rt = id_instr[20:16];
    assign specialcode = id_instr[5:0];
    always_comb begin
        target = jump_reg ? {reg_target[31:2], 2'b00}
               : jump     ? {id_pc_plus4[31:28], jump_index, 2'b00}
               :            id_pc_plus4 + {{14{branch_off[15]}}, branch_off, 2'b00};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            skid_pc     <= '0;
            skid_instr  <= '0;
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc       <= '0;
            id_pc_plus4 <= '0;
            misalign    <= 1'b0;
        end else begin
            misalign <= redir && jump_reg && (reg_target[1:0] != 2'b00);
            if (!stall) id_valid <= load_skid || load_mem;
            if (load_skid || load_mem) begin
                id_instr    <= load_skid ? skid_instr : imem_rdata;
                id_pc       <= src_pc;
                id_pc_plus4 <= src_pc + 32'd4;
            end
            case (state)
                IDLE: begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                REQ: begin
                    if (redir) begin
                        pc <= target;
                        if (acc) imem_addr <= target;
                        else state <= DROP;
                    end else if (acc) begin
                        pc <= pc + 32'd4;
                        if (stall) begin
                            state      <= FULL;
                            imem_req   <= 1'b0;
                            skid_instr <= imem_rdata;
                            skid_pc    <= imem_addr;
                        end else imem_addr <= pc + 32'd4;
                    end
                end
                // wrong-path request must complete before the target can be issued
                DROP: begin
                    if (acc) begin
                        state     <= REQ;
                        imem_addr <= pc;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= redir ? target : pc;
                        if (redir) pc <= target;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed test-plan scenarios plus a randomized run against a fetch-stream model.
module tb_if_stage;
    localparam logic [31:0] RPC = 32'h0000_3000;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic        jump_reg = 1'b0;
    logic        branch_taken = 1'b0;
    logic [25:0] jump_index = '0;
    logic [15:0] branch_off = '0;
    logic [31:0] reg_target = '0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [5:0]  funcode;
    logic [4:0]  rt;
    logic [5:0]  specialcode;
    logic        misalign;
    int checks = 0;
    int failures = 0;

    if_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .jump(jump),
        .jump_reg(jump_reg), .branch_taken(branch_taken), .jump_index(jump_index),
        .branch_off(branch_off), .reg_target(reg_target), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .funcode(funcode),
        .rt(rt), .specialcode(specialcode), .misalign(misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    assign imem_rdata = mem(imem_addr);

    task automatic idle_inputs();
        stall = 1'b0; jump = 1'b0; jump_reg = 1'b0; branch_taken = 1'b0;
        jump_index = '0; branch_off = '0; reg_target = '0;
    endtask

    task automatic restart(input logic ack);
        rst_n = 1'b0;
        idle_inputs();
        imem_ack = ack;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr} !== {1'b0, RPC}) begin
            failures++; $display("FAIL reset_imem got req=%b addr=%h exp req=0 addr=%h", imem_req, imem_addr, RPC);
        end
        checks++;
        if ({id_valid, id_instr, id_pc, id_pc_plus4} !== 97'd0) begin
            failures++; $display("FAIL reset_id got v=%b instr=%h pc=%h pc4=%h exp all 0", id_valid, id_instr, id_pc, id_pc_plus4);
        end
        checks++;
        if ({funcode, rt, specialcode, misalign} !== 18'd0) begin
            failures++; $display("FAIL reset_fields got f=%h rt=%h s=%h mis=%b exp all 0", funcode, rt, specialcode, misalign);
        end
    endtask

    task automatic test_sequential_jump();
        logic [31:0] ea, ep, ei;
        logic        ev;
        restart(1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            ea = RPC + 32'(4 * (k - 1));
            ev = k > 1;
            ep = ev ? RPC + 32'(4 * (k - 2)) : 32'd0;
            ei = ev ? mem(ep) : 32'd0;
            checks++;
            if ({imem_req, imem_addr, id_valid, id_pc, id_instr} !== {1'b1, ea, ev, ep, ei}) begin
                failures++;
                $display("FAIL seq k=%0d got req=%b addr=%h v=%b pc=%h instr=%h exp addr=%h v=%b pc=%h instr=%h",
                         k, imem_req, imem_addr, id_valid, id_pc, id_instr, ea, ev, ep, ei);
            end
            if (ev) begin
                checks++;
                if ({id_pc_plus4, funcode, rt, specialcode} !== {ep + 32'd4, ei[31:26], ei[20:16], ei[5:0]}) begin
                    failures++;
                    $display("FAIL seq_fields k=%0d got pc4=%h f=%h rt=%h s=%h exp pc4=%h f=%h rt=%h s=%h",
                             k, id_pc_plus4, funcode, rt, specialcode, ep + 32'd4, ei[31:26], ei[20:16], ei[5:0]);
                end
            end
        end
        jump = 1'b1; jump_index = 26'h0000C10;
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h0000_3040, 1'b0}) begin
            failures++; $display("FAIL jump_redirect got req=%b addr=%h v=%b exp req=1 addr=00003040 v=0", imem_req, imem_addr, id_valid);
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h0000_3040, mem(32'h3040)}) begin
            failures++; $display("FAIL jump_target got v=%b pc=%h instr=%h exp v=1 pc=00003040", id_valid, id_pc, id_instr);
        end
    endtask

    task automatic test_branch();
        restart(1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if ({id_valid, id_pc} !== {1'b1, 32'h0000_3008}) begin
            failures++; $display("FAIL branch_setup got v=%b pc=%h exp v=1 pc=00003008", id_valid, id_pc);
        end
        branch_taken = 1'b1; branch_off = 16'hFFFF;
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h0000_3008, 1'b0}) begin
            failures++; $display("FAIL branch_redirect got req=%b addr=%h v=%b exp req=1 addr=00003008 v=0", imem_req, imem_addr, id_valid);
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h0000_3008, mem(32'h3008)}) begin
            failures++; $display("FAIL branch_target got v=%b pc=%h instr=%h exp v=1 pc=00003008", id_valid, id_pc, id_instr);
        end
    endtask

    task automatic test_drop();
        restart(1'b1);
        repeat (2) @(negedge clk);
        imem_ack = 1'b0; jump = 1'b1; jump_index = 26'h0000C40;
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            checks++;
            if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h0000_3004, 1'b0}) begin
                failures++; $display("FAIL drop_hold w=%0d got req=%b addr=%h v=%b exp req=1 addr=00003004 v=0", w, imem_req, imem_addr, id_valid);
            end
            idle_inputs();
        end
        imem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr, id_valid} !== {1'b1, 32'h0000_3100, 1'b0}) begin
            failures++; $display("FAIL drop_retarget got req=%b addr=%h v=%b exp req=1 addr=00003100 v=0", imem_req, imem_addr, id_valid);
        end
        @(negedge clk);
        checks++;
        if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h0000_3100, mem(32'h3100)}) begin
            failures++; $display("FAIL drop_target got v=%b pc=%h instr=%h exp v=1 pc=00003100", id_valid, id_pc, id_instr);
        end
    endtask

    task automatic test_stall();
        restart(1'b1);
        repeat (2) @(negedge clk);
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++;
            if ({imem_req, id_valid, id_pc, id_instr} !== {1'b0, 1'b1, RPC, mem(RPC)}) begin
                failures++; $display("FAIL stall_hold s=%0d got req=%b v=%b pc=%h instr=%h exp req=0 v=1 pc=%h", s, imem_req, id_valid, id_pc, id_instr, RPC);
            end
        end
        stall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({id_valid, id_pc, id_instr} !== {1'b1, RPC + 32'(4 * (k + 1)), mem(RPC + 32'(4 * (k + 1)))}) begin
                failures++; $display("FAIL stall_resume k=%0d got v=%b pc=%h exp pc=%h", k, id_valid, id_pc, RPC + 32'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_jump_reg_reset();
        restart(1'b1);
        repeat (2) @(negedge clk);
        jump_reg = 1'b1; jump = 1'b1; reg_target = 32'h0000_3011;
        @(negedge clk);
        checks++;
        if ({imem_addr, misalign, id_valid} !== {32'h0000_3010, 1'b1, 1'b0}) begin
            failures++; $display("FAIL jr_redirect got addr=%h mis=%b v=%b exp addr=00003010 mis=1 v=0", imem_addr, misalign, id_valid);
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({misalign, id_valid, id_pc} !== {1'b0, 1'b1, 32'h0000_3010}) begin
            failures++; $display("FAIL jr_after got mis=%b v=%b pc=%h exp mis=0 v=1 pc=00003010", misalign, id_valid, id_pc);
        end
        restart(1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr, id_valid} !== {1'b0, RPC, 1'b0}) begin
            failures++; $display("FAIL reset_mid got req=%b addr=%h v=%b exp req=0 addr=%h v=0", imem_req, imem_addr, id_valid, RPC);
        end
        imem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({imem_req, imem_addr, id_valid} !== {1'b1, RPC, 1'b0}) begin
            failures++; $display("FAIL reset_restart got req=%b addr=%h v=%b exp req=1 addr=%h v=0", imem_req, imem_addr, id_valid, RPC);
        end
        @(negedge clk);
        checks++;
        if ({id_valid, id_pc} !== {1'b1, RPC}) begin
            failures++; $display("FAIL reset_first got v=%b pc=%h exp v=1 pc=%h", id_valid, id_pc, RPC);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, ei, pp4, sx, p_pc, p_instr, p_addr, p_rt;
        logic [25:0] p_idx;
        logic [15:0] p_off;
        logic        p_valid, p_req, p_ack, p_stall, p_jr, p_j, p_bt, p_redir;
        int          n_new;
        restart(1'b0);
        exp_pc = RPC;
        n_new = 0;
        for (int c = 0; c < 3000; c++) begin
            stall = $urandom_range(0, 4) == 0;
            imem_ack = $urandom_range(0, 9) < 7;
            jump_reg = $urandom_range(0, 19) == 0;
            jump = jump_reg || ($urandom_range(0, 19) == 0);
            branch_taken = $urandom_range(0, 9) == 0;
            jump_index = 26'($urandom);
            branch_off = 16'($urandom);
            reg_target = $urandom;
            p_valid = id_valid; p_pc = id_pc; p_instr = id_instr; p_req = imem_req; p_addr = imem_addr;
            p_ack = imem_ack; p_stall = stall; p_jr = jump_reg; p_j = jump; p_bt = branch_taken;
            p_idx = jump_index; p_off = branch_off; p_rt = reg_target;
            @(negedge clk);
            p_redir = p_valid && !p_stall && (p_jr || p_j || p_bt);
            if (p_req && !p_ack) begin
                checks++;
                if ({imem_req, imem_addr} !== {1'b1, p_addr}) begin
                    failures++; $display("FAIL rnd_hold c=%0d got req=%b addr=%h exp req=1 addr=%h", c, imem_req, imem_addr, p_addr);
                end
            end
            checks++;
            if (misalign !== (p_redir && p_jr && p_rt[1:0] != 2'b00)) begin
                failures++; $display("FAIL rnd_misalign c=%0d got %b", c, misalign);
            end
            if (p_valid && p_stall) begin
                checks++;
                if ({id_valid, id_pc, id_instr} !== {1'b1, p_pc, p_instr}) begin
                    failures++; $display("FAIL rnd_stall c=%0d got v=%b pc=%h exp v=1 pc=%h", c, id_valid, id_pc, p_pc);
                end
            end else if (p_redir) begin
                checks++;
                if (id_valid !== 1'b0) begin
                    failures++; $display("FAIL rnd_flush c=%0d got v=%b exp v=0", c, id_valid);
                end
            end else if (id_valid) begin
                ei = mem(exp_pc);
                checks++;
                if ({id_pc, id_instr, id_pc_plus4, funcode, rt, specialcode} !== {exp_pc, ei, exp_pc + 32'd4, ei[31:26], ei[20:16], ei[5:0]}) begin
                    failures++; $display("FAIL rnd_stream c=%0d got pc=%h instr=%h pc4=%h exp pc=%h instr=%h", c, id_pc, id_instr, id_pc_plus4, exp_pc, ei);
                end
                exp_pc = exp_pc + 32'd4;
                n_new++;
            end
            if (p_redir) begin
                pp4 = p_pc + 32'd4;
                sx = {{16{p_off[15]}}, p_off};
                exp_pc = p_jr ? {p_rt[31:2], 2'b00} : p_j ? {pp4[31:28], p_idx, 2'b00} : pp4 + (sx << 2);
            end
        end
        idle_inputs();
        checks++;
        if (n_new < 300) begin
            failures++; $display("FAIL rnd_progress got %0d instructions exp at least 300", n_new);
        end
    endtask

    initial begin
        test_reset();
        test_sequential_jump();
        test_branch();
        test_drop();
        test_stall();
        test_jump_reg_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
